vend_dispense_scheduler: RTL and testbench

Sequences physical delivery after the vending machine has accepted payment. It takes a latched order (tea/coffee/milk cup counts plus balance owed) and drives one shared dispenser actuator one cup at a time, arbitrating round-robin between the three products. It then pays out the balance as coins through a change-hopper handshake. It sits between the payment/billing logic and the dispenser and hopper drivers.

---
 rtl/vend_dispense_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_vend_dispense_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_scheduler.sv
// rtl/vend_dispense_scheduler.sv - round-robin cup dispense sequencer with greedy coin payout
// One shared dispenser is served a cup at a time; change is paid largest-coin-first.
module vend_dispense_scheduler #(
  parameter int ACK_TIMEOUT = 255,
  parameter int GAP_CYCLES  = 4
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        start,
  input  logic [3:0]  tea_reqd,
  input  logic [3:0]  coffee_reqd,
  input  logic [3:0]  milk_reqd,
  input  logic [15:0] balance,
  input  logic        abort,
  input  logic        disp_ack,
  input  logic        chg_ack,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        disp_req,
  output logic [1:0]  disp_sel,
  output logic        chg_req,
  output logic [2:0]  chg_coin,
  output logic [3:0]  tea_served,
  output logic [3:0]  coffee_served,
  output logic [3:0]  milk_served,
  output logic [15:0] change_residual
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_REQ, S_GAP, S_CHANGE, S_CHG_WAIT, S_DONE, S_FAULT
  } state_e;

  state_e      state_q;
  logic [3:0]  rem_q    [3];
  logic [3:0]  served_q [3];
  logic [15:0] bal_q;
  logic [1:0]  rr_q;
  logic [31:0] tmr_q;
  logic [31:0] gap_q;
  logic        busy_q, done_q, fault_q, disp_req_q, chg_req_q;
  logic [1:0]  disp_sel_q;
  logic [2:0]  chg_coin_q;
  logic [15:0] residual_q;

  logic [1:0]  pick_d;
  logic [1:0]  idx_d;
  logic        found_d;
  logic [2:0]  coin_d;
  logic [15:0] coin_val_d;
  logic        tmo_d;

  function automatic logic [1:0] next3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First product with cups left, scanning from the round-robin pointer.
  always_comb begin
    pick_d  = rr_q;
    found_d = 1'b0;
    idx_d   = rr_q;
    for (int i = 0; i < 3; i++) begin
      if (!found_d && rem_q[idx_d] != 4'd0) begin
        found_d = 1'b1;
        pick_d  = idx_d;
      end
      idx_d = next3(idx_d);
    end
  end

  always_comb begin
    coin_d     = 3'd0;
    coin_val_d = 16'd25;
    if (bal_q >= 16'd1000) begin
      coin_d = 3'd5; coin_val_d = 16'd1000;
    end else if (bal_q >= 16'd500) begin
      coin_d = 3'd4; coin_val_d = 16'd500;
    end else if (bal_q >= 16'd200) begin
      coin_d = 3'd3; coin_val_d = 16'd200;
    end else if (bal_q >= 16'd100) begin
      coin_d = 3'd2; coin_val_d = 16'd100;
    end else if (bal_q >= 16'd50) begin
      coin_d = 3'd1; coin_val_d = 16'd50;
    end
  end

  assign tmo_d = (tmr_q + 32'd1) >= 32'(ACK_TIMEOUT);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q    <= S_IDLE;
      bal_q      <= 16'd0;
      rr_q       <= 2'd0;
      tmr_q      <= 32'd0;
      gap_q      <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      disp_req_q <= 1'b0;
      disp_sel_q <= 2'd0;
      chg_req_q  <= 1'b0;
      chg_coin_q <= 3'd0;
      residual_q <= 16'd0;
      for (int i = 0; i < 3; i++) begin
        rem_q[i]    <= 4'd0;
        served_q[i] <= 4'd0;
      end
    end else if (abort && state_q != S_IDLE) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      disp_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      tmr_q      <= 32'd0;
      gap_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          rem_q[0]   <= tea_reqd;
          rem_q[1]   <= coffee_reqd;
          rem_q[2]   <= milk_reqd;
          bal_q      <= balance;
          residual_q <= 16'd0;
          for (int i = 0; i < 3; i++) served_q[i] <= 4'd0;
          busy_q     <= 1'b1;
          state_q    <= S_SELECT;
        end
        S_SELECT: if (found_d) begin
          disp_sel_q <= pick_d;
          disp_req_q <= 1'b1;
          tmr_q      <= 32'd0;
          state_q    <= S_REQ;
        end else begin
          state_q    <= S_CHANGE;
        end
        S_REQ: if (disp_ack) begin
          disp_req_q           <= 1'b0;
          rem_q[disp_sel_q]    <= rem_q[disp_sel_q] - 4'd1;
          served_q[disp_sel_q] <= served_q[disp_sel_q] + 4'd1;
          rr_q                 <= next3(disp_sel_q);
          gap_q                <= 32'd0;
          state_q              <= (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
        end else if (tmo_d) begin
          disp_req_q <= 1'b0;
          fault_q    <= 1'b1;
          state_q    <= S_FAULT;
        end else if (tmr_q != '1) begin
          tmr_q <= tmr_q + 32'd1;
        end
        S_GAP: if (gap_q == 32'(GAP_CYCLES - 1)) begin
          state_q <= S_SELECT;
        end else begin
          gap_q <= gap_q + 32'd1;
        end
        S_CHANGE: if (bal_q >= 16'd25) begin
          chg_coin_q <= coin_d;
          chg_req_q  <= 1'b1;
          tmr_q      <= 32'd0;
          state_q    <= S_CHG_WAIT;
        end else begin
          residual_q <= bal_q;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        S_CHG_WAIT: if (chg_ack) begin
          chg_req_q <= 1'b0;
          bal_q     <= bal_q - coin_val_d;
          state_q   <= S_CHANGE;
        end else if (tmo_d) begin
          chg_req_q <= 1'b0;
          fault_q   <= 1'b1;
          state_q   <= S_FAULT;
        end else if (tmr_q != '1) begin
          tmr_q <= tmr_q + 32'd1;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign fault           = fault_q;
  assign disp_req        = disp_req_q;
  assign disp_sel        = disp_sel_q;
  assign chg_req         = chg_req_q;
  assign chg_coin        = chg_coin_q;
  assign tea_served      = served_q[0];
  assign coffee_served   = served_q[1];
  assign milk_served     = served_q[2];
  assign change_residual = residual_q;

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// tb/tb_vend_dispense_scheduler.sv - directed and randomized self-checking bench for vend_dispense_scheduler
// Expected cup/coin sequences come from a queue-based model of the round-robin and greedy payout rules.
module tb_vend_dispense_scheduler;

  localparam int ACK_TO = 8;
  localparam int GAP    = 4;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  tea_reqd = 4'd0, coffee_reqd = 4'd0, milk_reqd = 4'd0;
  logic [15:0] balance = 16'd0;
  logic        abort = 1'b0;
  logic        auto_dack = 1'b0, man_dack = 1'b0, auto_cack = 1'b0;
  logic        disp_ack, chg_ack;
  logic        busy, done, fault, disp_req, chg_req;
  logic [1:0]  disp_sel;
  logic [2:0]  chg_coin;
  logic [3:0]  tea_served, coffee_served, milk_served;
  logic [15:0] change_residual;

  assign disp_ack = auto_dack | man_dack;
  assign chg_ack  = auto_cack;

  always #5 pclk = ~pclk;

  vend_dispense_scheduler #(.ACK_TIMEOUT(ACK_TO), .GAP_CYCLES(GAP)) dut (
    .pclk(pclk), .prst_n(prst_n), .start(start),
    .tea_reqd(tea_reqd), .coffee_reqd(coffee_reqd), .milk_reqd(milk_reqd),
    .balance(balance), .abort(abort), .disp_ack(disp_ack), .chg_ack(chg_ack),
    .busy(busy), .done(done), .fault(fault), .disp_req(disp_req), .disp_sel(disp_sel),
    .chg_req(chg_req), .chg_coin(chg_coin), .tea_served(tea_served),
    .coffee_served(coffee_served), .milk_served(milk_served),
    .change_residual(change_residual)
  );

  int   checks = 0, errors = 0;
  logic ack_en = 1'b1, ack_rand = 1'b0;
  int   ack_fix = 3;
  int   mdl_rr = 0;
  int   sel_q[$], coin_q[$], gap_q[$];
  int   done_cnt = 0, low_cnt = 0;
  logic prev_dreq = 1'b0, prev_creq = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {26'd0, busy, done, fault, disp_req, disp_sel, chg_req, chg_coin,
            tea_served, coffee_served, milk_served, change_residual};
  endfunction

  function automatic int pick_dly();
    return ack_rand ? int'($urandom_range(0, 6)) : ack_fix;
  endfunction

  // Handshake responders: ack a configurable number of cycles after the request is seen.
  initial begin
    int cnt;
    cnt = -1;
    forever begin
      @(negedge pclk);
      auto_dack = 1'b0;
      if (!ack_en || !disp_req) cnt = -1;
      else if (cnt == -1) cnt = pick_dly();
      else if (cnt > 0) cnt--;
      if (ack_en && disp_req && cnt == 0) begin
        auto_dack = 1'b1;
        cnt = -2;
      end
    end
  end

  initial begin
    int cnt;
    cnt = -1;
    forever begin
      @(negedge pclk);
      auto_cack = 1'b0;
      if (!ack_en || !chg_req) cnt = -1;
      else if (cnt == -1) cnt = pick_dly();
      else if (cnt > 0) cnt--;
      if (ack_en && chg_req && cnt == 0) begin
        auto_cack = 1'b1;
        cnt = -2;
      end
    end
  end

  initial begin
    forever begin
      @(negedge pclk);
      if (disp_req && !prev_dreq) begin
        if (sel_q.size() > 0) gap_q.push_back(low_cnt);
        sel_q.push_back(int'(disp_sel));
      end
      if (!disp_req) low_cnt++;
      else low_cnt = 0;
      if (chg_req && !prev_creq) coin_q.push_back(int'(chg_coin));
      if (done) done_cnt++;
      prev_dreq = disp_req;
      prev_creq = chg_req;
    end
  end

  task automatic wait_for(input int which, input int limit, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge pclk);
      if ((which == 0 && disp_req) || (which == 1 && chg_req) || (which == 2 && !busy)) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_wait"}, 64'(ok), 64'd1);
  endtask

  task automatic give_order(input int t, input int c, input int m, input int b);
    @(negedge pclk);
    sel_q.delete(); coin_q.delete(); gap_q.delete();
    done_cnt = 0;
    tea_reqd = 4'(t); coffee_reqd = 4'(c); milk_reqd = 4'(m); balance = 16'(b);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic run_order(input int t, input int c, input int m, input int b, input string tag);
    int exp_sel[$];
    int exp_coin[$];
    int rem[3];
    int vals[6] = '{25, 50, 100, 200, 500, 1000};
    int rr, bal, pick;
    rem = '{t, c, m};
    rr = mdl_rr;
    forever begin
      pick = -1;
      for (int k = 0; k < 3; k++)
        if (pick < 0 && rem[(rr + k) % 3] > 0) pick = (rr + k) % 3;
      if (pick < 0) break;
      exp_sel.push_back(pick);
      rem[pick]--;
      rr = (pick + 1) % 3;
    end
    mdl_rr = rr;
    bal = b;
    while (bal >= 25) begin
      for (int k = 5; k >= 0; k--)
        if (vals[k] <= bal) begin
          exp_coin.push_back(k);
          bal -= vals[k];
          break;
        end
    end

    give_order(t, c, m, b);
    wait_for(2, 3000, tag);
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_fault"}, 64'(fault), 64'd0);
    chk({tag, "_served"}, {52'd0, tea_served, coffee_served, milk_served},
        {52'd0, 4'(t), 4'(c), 4'(m)});
    chk({tag, "_resid"}, 64'(change_residual), 64'(bal));
    chk({tag, "_nsel"}, 64'(sel_q.size()), 64'(exp_sel.size()));
    for (int i = 0; i < exp_sel.size() && i < sel_q.size(); i++)
      chk({tag, "_sel"}, 64'(sel_q[i]), 64'(exp_sel[i]));
    chk({tag, "_ncoin"}, 64'(coin_q.size()), 64'(exp_coin.size()));
    for (int i = 0; i < exp_coin.size() && i < coin_q.size(); i++)
      chk({tag, "_coin"}, 64'(coin_q[i]), 64'(exp_coin[i]));
    for (int i = 0; i < gap_q.size(); i++)
      chk({tag, "_gap"}, 64'(gap_q[i]), 64'(GAP + 1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d1_sel[4] = '{0, 1, 2, 0};
    int d2_coin[5] = '{5, 4, 3, 1, 0};

    repeat (3) @(negedge pclk);
    chk("reset_outs", outs(), 64'd0);
    prst_n = 1'b1;
    @(negedge pclk);
    chk("idle_outs", outs(), 64'd0);

    run_order(2, 1, 1, 0, "d_cups");
    chk("d_cups_nsel4", 64'(sel_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < sel_q.size(); i++)
      chk("d_cups_const_sel", 64'(sel_q[i]), 64'(d1_sel[i]));

    run_order(0, 0, 0, 1775, "d_1775");
    for (int i = 0; i < 5 && i < coin_q.size(); i++)
      chk("d_1775_const_coin", 64'(coin_q[i]), 64'(d2_coin[i]));
    run_order(0, 0, 0, 130, "d_130");
    chk("d_130_const_resid", 64'(change_residual), 64'd5);

    ack_en = 1'b0;
    give_order(1, 0, 0, 0);
    wait_for(0, 50, "to_req");
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (fault) break;
      n++;
    end
    chk("to_cycles", 64'(n), 64'(ACK_TO));
    chk("to_fault", 64'(fault), 64'd1);
    chk("to_dreq", 64'(disp_req), 64'd0);
    repeat (3) @(negedge pclk);
    chk("to_sticky", {62'd0, fault, busy}, 64'd3);
    abort = 1'b1;
    @(negedge pclk);
    abort = 1'b0;
    chk("to_abort", {61'd0, busy, fault, disp_req}, 64'd0);
    chk("to_nodone", 64'(done_cnt), 64'd0);
    chk("to_served", 64'(tea_served), 64'd0);

    give_order(2, 0, 0, 0);
    wait_for(0, 50, "ab_req1");
    man_dack = 1'b1;
    @(negedge pclk);
    man_dack = 1'b0;
    chk("ab_served1", 64'(tea_served), 64'd1);
    wait_for(0, 50, "ab_req2");
    man_dack = 1'b1;
    abort = 1'b1;
    @(negedge pclk);
    man_dack = 1'b0;
    abort = 1'b0;
    chk("ab_idle", {62'd0, busy, disp_req}, 64'd0);
    chk("ab_served", 64'(tea_served), 64'd1);
    chk("ab_nodone", 64'(done_cnt), 64'd0);
    mdl_rr = 1;
    ack_en = 1'b1;
    run_order(0, 0, 0, 0, "ab_next");
    run_order(1, 1, 1, 60, "ab_rr");

    ack_rand = 1'b1;
    for (int k = 0; k < 12; k++)
      run_order(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2000)), "rnd");

    ack_en = 1'b0;
    give_order(0, 0, 0, 100);
    wait_for(1, 50, "rst_chg");
    chk("rst_coin", 64'(chg_coin), 64'd2);
    @(negedge pclk);
    tea_reqd = 4'd3;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    chk("rst_ignore_start", {58'd0, busy, chg_req, tea_served}, {58'd0, 2'b11, 4'd0});
    #2;
    prst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 64'd0);
    @(negedge pclk);
    prst_n = 1'b1;
    mdl_rr = 0;
    ack_en = 1'b1;
    for (int k = 0; k < 4; k++)
      run_order(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2000)), "rnd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
